// File: rtl/pmem_arbiter_adaptor.sv
`default_nettype none
// ============================================================================
//  Module      : pmem_arbiter_adaptor
//  Description : Round-robin arbiter and line/burst adaptor. Serialises
//                whole-line read/write requests from NUM_PORTS clients onto
//                one burst-oriented physical memory port, moving each line
//                as LINE_W/BURST_W beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module pmem_arbiter_adaptor #(
    parameter int NUM_PORTS = 2,
    parameter int LINE_W    = 256,
    parameter int BURST_W   = 64,
    parameter int ADDR_W    = 32
) (
    input  logic                        clk,
    input  logic                        reset_n,
    // line clients
    input  logic [NUM_PORTS-1:0]        req_read_i,
    input  logic [NUM_PORTS-1:0]        req_write_i,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_PORTS*LINE_W-1:0] req_line_i,
    output logic [LINE_W-1:0]           req_line_o,
    output logic [NUM_PORTS-1:0]        req_resp_o,
    // physical memory
    output logic [ADDR_W-1:0]           address_o,
    output logic                        read_o,
    output logic                        write_o,
    output logic [BURST_W-1:0]          burst_o,
    input  logic [BURST_W-1:0]          burst_i,
    input  logic                        resp_i
);

    localparam int c_beats = LINE_W / BURST_W;
    localparam int c_cnt_w = (c_beats > 1) ? $clog2(c_beats) : 1;
    localparam int c_ptr_w = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(c_beats - 1);
    localparam logic [c_ptr_w:0]   c_num_ports = (c_ptr_w + 1)'(NUM_PORTS);
    localparam logic [c_ptr_w-1:0] c_last_port = c_ptr_w'(NUM_PORTS - 1);
    // Clears the byte-offset-within-line bits of the request address.
    localparam logic [ADDR_W-1:0]  c_addr_mask = ~(ADDR_W'(LINE_W / 8 - 1));

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_rd   = 2'd1;
    localparam logic [1:0] c_st_wr   = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [c_ptr_w-1:0]   r_rr;
    logic [c_ptr_w-1:0]   r_grant;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [ADDR_W-1:0]    r_addr;
    logic [LINE_W-1:0]    r_wr_line;
    logic [LINE_W-1:0]    r_rd_line;

    logic [NUM_PORTS-1:0] w_cand;
    logic                 w_found;
    logic [c_ptr_w-1:0]   w_win;
    logic [c_ptr_w:0]     w_idx;
    logic [c_ptr_w-1:0]   w_rr_nxt;
    logic                 w_last;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [LINE_W-1:0]    w_sel_line;

    assign w_cand     = req_read_i | req_write_i;
    assign w_last     = resp_i && (r_cnt == c_last_beat);
    assign w_rr_nxt   = (w_win == c_last_port) ? '0 : w_win + 1'b1;
    assign w_sel_addr = req_addr_i[w_win*ADDR_W +: ADDR_W];
    assign w_sel_line = req_line_i[w_win*LINE_W +: LINE_W];

    // Round-robin search: first candidate at rr, rr+1, ... (mod NUM_PORTS).
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_idx = {1'b0, r_rr} + (c_ptr_w + 1)'(i);
            if (w_idx >= c_num_ports) begin
                w_idx = w_idx - c_num_ports;
            end
            if (!w_found && w_cand[w_idx[c_ptr_w-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[c_ptr_w-1:0];
            end
        end
    end

    // Next-state logic; a write request wins over a read on the same port.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_found) begin
                    w_state_nxt = req_write_i[w_win] ? c_st_wr : c_st_rd;
                end
            end
            c_st_rd, c_st_wr: begin
                if (w_last) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // State register, grant/address/line latch, beat counter and read assembly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_st_idle;
            r_rr      <= '0;
            r_grant   <= '0;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_wr_line <= '0;
            r_rd_line <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_st_idle: begin
                    if (w_found) begin
                        r_grant   <= w_win;
                        r_rr      <= w_rr_nxt;
                        r_addr    <= w_sel_addr & c_addr_mask;
                        r_wr_line <= w_sel_line;
                        r_cnt     <= '0;
                    end
                end
                c_st_rd: begin
                    if (resp_i) begin
                        r_rd_line[r_cnt*BURST_W +: BURST_W] <= burst_i;
                        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                    end
                end
                c_st_wr: begin
                    if (resp_i) begin
                        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode registered state only; nothing passes through from inputs.
    assign read_o     = (r_state == c_st_rd);
    assign write_o    = (r_state == c_st_wr);
    assign address_o  = r_addr;
    assign burst_o    = (r_state == c_st_wr) ? r_wr_line[r_cnt*BURST_W +: BURST_W] : '0;
    assign req_resp_o = (r_state == c_st_done) ? (NUM_PORTS'(1) << r_grant) : '0;
    assign req_line_o = r_rd_line;

endmodule
`default_nettype wire
